// File: rtl/aes_pkg.sv
// aes_pkg: shared AES column-mixing constants, FSM state type and GF(2^8) xtime helper
// Contents: AES_POLY (reduction constant for x^8 = x^4+x^3+x+1), MODE_FWD/MODE_INV, state_t, xtime()
package aes_pkg;
  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_HOLD} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/gf_mix_col.sv
// gf_mix_col: combinational (Inv)MixColumns of one 32-bit AES column
// Ports: i_col  - column in, row 0 in [31:24]
//        i_mode - MODE_FWD (02 03 01 01) or MODE_INV (0e 0b 0d 09)
//        o_col  - transformed column, same byte layout
module gf_mix_col
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_mode,
  output logic [31:0] o_col
);
  logic [7:0] w_a  [4];
  logic [7:0] w_x2 [4];
  logic [7:0] w_x4 [4];
  logic [7:0] w_x8 [4];
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_a[i]  = i_col[31-8*i -: 8];
    assign w_x2[i] = xtime(w_a[i]);
    assign w_x4[i] = xtime(w_x2[i]);
    assign w_x8[i] = xtime(w_x4[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_row
    // Inverse coefficients decompose as 0e=8^4^2, 0b=8^2^1, 0d=8^4^1, 09=8^1.
    logic [7:0] w_fwd, w_inv;
    assign w_fwd = w_x2[i] ^ w_x2[(i+1)%4] ^ w_a[(i+1)%4] ^ w_a[(i+2)%4] ^ w_a[(i+3)%4];
    assign w_inv = (w_x8[i] ^ w_x4[i] ^ w_x2[i])
                 ^ (w_x8[(i+1)%4] ^ w_x2[(i+1)%4] ^ w_a[(i+1)%4])
                 ^ (w_x8[(i+2)%4] ^ w_x4[(i+2)%4] ^ w_a[(i+2)%4])
                 ^ (w_x8[(i+3)%4] ^ w_a[(i+3)%4]);
    assign o_col[31-8*i -: 8] = (i_mode == MODE_INV) ? w_inv : w_fwd;
  end
endmodule

// File: rtl/mix_column_engine.sv
// mix_column_engine: iterative AES MixColumns/InvMixColumns over a 128-bit state
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_ready/data_in/mode - block input handshake, mode 0 fwd / 1 inv
//        out_valid/out_ready/data_out   - result handshake, data held stable until taken
//        busy                           - engine not idle
module mix_column_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam logic [1:0] LAST_BEAT = 2'(4 / COLS_PER_CYCLE - 1);
  state_t r_state, w_state_nx;
  logic [1:0] r_beat;
  logic [127:0] r_res, r_out, w_res_nx;
  logic r_mode, r_live, w_accept, w_last;
  int w_base;
  logic [31:0] w_col_in [COLS_PER_CYCLE];
  logic [31:0] w_col_out [COLS_PER_CYCLE];
  assign w_base   = int'(r_beat) * COLS_PER_CYCLE;
  assign w_last   = r_beat == LAST_BEAT;
  // r_live keeps in_ready low until the first clock edge after reset release.
  assign in_ready = r_live && r_state == ST_IDLE;
  assign w_accept = in_valid && in_ready;
  assign out_valid = r_state == ST_HOLD;
  assign busy      = r_state != ST_IDLE;
  assign data_out  = REG_OUT ? r_out : r_res;
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign w_col_in[j] = r_res[127-32*(w_base+j) -: 32];
    gf_mix_col u_col (.i_col(w_col_in[j]), .i_mode(r_mode), .o_col(w_col_out[j]));
  end
  always_comb begin
    w_res_nx = r_res;
    for (int j = 0; j < COLS_PER_CYCLE; j++) w_res_nx[127-32*(w_base+j) -: 32] = w_col_out[j];
  end
  always_comb begin
    w_state_nx = r_state;
    if (r_state == ST_IDLE && w_accept) w_state_nx = ST_CALC;
    else if (r_state == ST_CALC && w_last) w_state_nx = ST_HOLD;
    else if (r_state == ST_HOLD && out_ready) w_state_nx = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_beat <= 2'd0;
      r_res  <= '0;
      r_out  <= '0;
      r_mode <= MODE_FWD;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_res  <= data_in;
        r_mode <= mode;
        r_beat <= 2'd0;
      end else if (r_state == ST_CALC) begin
        r_res  <= w_res_nx;
        r_beat <= w_last ? 2'd0 : r_beat + 2'd1;
        if (w_last) r_out <= w_res_nx;
      end
    end
  end
endmodule

// File: tb/tb_mix_column_engine.sv
// tb_mix_column_engine: scoreboard bench over three engine configurations sharing one stimulus stream
module tb_mix_column_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b1;
  logic [127:0] data_in = '0;
  logic [127:0] exp_data = '0;
  logic ir [3];
  logic ov [3];
  logic bz [3];
  logic [127:0] dout [3];
  int npass = 0, ntot = 0, npop = 0, nblk = 0;

  localparam logic [127:0] V1I = {4{32'hdb135345}};
  localparam logic [127:0] V1O = {4{32'h8e4da1bc}};
  localparam logic [127:0] V2I = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] V2O = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] FI  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FO  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s got=%h want=%h", name, act, req);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CPC = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    localparam bit RO = (k != 1);
    logic [127:0] q [$];
    logic [127:0] pd = '0;
    time t_acc = 0;
    logic pv = 1'b0, ps = 1'b0;
    mix_column_engine #(.COLS_PER_CYCLE(CPC), .REG_OUT(RO)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[k]),
      .data_in(data_in), .mode(mode), .out_valid(ov[k]), .out_ready(out_ready),
      .data_out(dout[k]), .busy(bz[k])
    );
    always @(posedge clk) if (in_valid && ir[k]) begin
      q.push_back(exp_data);
      t_acc = $time;
    end
    always @(negedge rst_n) q.delete();
    always @(negedge clk) begin
      if (ov[k] && !pv) chk($sformatf("latency_c%0d", CPC), 128'(($time - t_acc + 5) / 10), 128'(4 / CPC + 1));
      if (ov[k] && ps) begin
        chk($sformatf("stable_c%0d", CPC), dout[k], pd);
        chk($sformatf("in_ready_stall_c%0d", CPC), 128'(ir[k]), 128'(0));
      end
      if (ov[k] && out_ready) begin
        if (q.size() == 0) chk($sformatf("spurious_valid_c%0d", CPC), 128'(ov[k]), 128'(0));
        else begin
          chk($sformatf("data_c%0d", CPC), dout[k], q.pop_front());
          npop++;
        end
      end
      pv = ov[k];
      ps = ov[k] && !out_ready;
      pd = dout[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_out_valid%0d", tag, k), 128'(ov[k]), 128'(0));
      chk($sformatf("%s_busy%0d", tag, k), 128'(bz[k]), 128'(0));
      chk($sformatf("%s_data_out%0d", tag, k), dout[k], 128'(0));
      chk($sformatf("%s_in_ready%0d", tag, k), 128'(ir[k]), 128'(0));
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(ir[0] && ir[1] && ir[2]) && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) chk("idle_timeout", 128'({ir[0], ir[1], ir[2]}), 128'(3'b111));
  endtask

  task automatic send(input logic [127:0] d, input logic m, input logic [127:0] e);
    wait_idle();
    data_in = d;
    mode = m;
    exp_data = e;
    in_valid = 1'b1;
    nblk++;
    tick();
    in_valid = 1'b0;
    mode = ~m;
    data_in = ~d;
  endtask

  initial begin
    int w;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    tick();
    tick();
    #3 rst_n = 1'b1;
    #1 for (int k = 0; k < 3; k++) chk($sformatf("in_ready_before_edge%0d", k), 128'(ir[k]), 128'(0));
    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("in_ready_after_edge%0d", k), 128'(ir[k]), 128'(1));

    send(V1I, 1'b0, V1O);
    send(V2I, 1'b0, V2O);
    send(V2O, 1'b1, V2I);
    send(V1O, 1'b1, V1I);
    send(FI, 1'b0, FO);
    send(FO, 1'b1, FI);
    send({4{32'hffffffff}}, 1'b0, {4{32'hffffffff}});
    send('0, 1'b1, '0);

    wait_idle();
    out_ready = 1'b0;
    send(V2I, 1'b0, V2O);
    data_in = FI;
    mode = 1'b0;
    exp_data = FO;
    in_valid = 1'b1;
    repeat (14) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_in_ready%0d", k), 128'(ir[k]), 128'(0));
      chk($sformatf("stall_out_valid%0d", k), 128'(ov[k]), 128'(1));
    end
    out_ready = 1'b1;
    nblk++;
    w = 0;
    do begin
      tick();
      w++;
    end while (!(bz[0] && !ov[0]) && w < 20);
    if (w >= 20) chk("second_accept_timeout", 128'({bz[0], ov[0]}), 128'(2'b10));
    in_valid = 1'b0;
    mode = 1'b1;
    wait_idle();

    out_ready = 1'b0;
    send(V1I, 1'b0, V1O);
    repeat (2) tick();
    rst_n = 1'b0;
    nblk--;
    #1 check_reset_outputs("midreset");
    tick();
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) chk($sformatf("no_valid_after_reset%0d", k), 128'(ov[k]), 128'(0));
    send(V1O, 1'b1, V1I);
    wait_idle();
    tick();
    chk("result_count", 128'(npop), 128'(3 * nblk));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=finish", ntot);
    $fatal(1);
  end
endmodule

// File: doc/mix_column_engine.md
MIX_COLUMN_ENGINE -- requirements
Module: mix_column_engine

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, columns processed per beat; legal values 1, 2 and 4.
REQ-002 Parameter REG_OUT, default 1, selects the output path: 1 = registered data_out, 0 = data_out driven straight from the result register.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  data_in and mode are valid.
REQ-006 in_ready  output  1  engine can accept a block.
REQ-007 data_in  input  128  AES state; column c = bits [127-32c -: 32]; row 0 of each column = its MSB byte.
REQ-008 mode  input  1  0 = MixColumns (02 03 01 01), 1 = InvMixColumns (0e 0b 0d 09).
REQ-009 out_valid  output  1  data_out holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 data_out  output  128  transformed state, same column and byte layout as data_in.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 State machine IDLE -> CALC -> HOLD -> IDLE; no other states.
REQ-014 in_ready = 1 only in IDLE; a block is accepted when in_valid & in_ready; data_in and mode are latched on that edge.
REQ-015 IDLE -> CALC on accept; otherwise stay in IDLE.
REQ-016 CALC: each cycle, COLS_PER_CYCLE columns are transformed, starting at column 0 in ascending order, and written in place into the result register.
REQ-017 A 2-bit beat counter runs 0 .. (4/COLS_PER_CYCLE - 1) and wraps to 0; CALC -> HOLD on the last beat.
REQ-018 HOLD: out_valid = 1; data_out stays stable until out_valid & out_ready; HOLD -> IDLE on that edge.
REQ-019 Latency from accept edge to first out_valid high = 4/COLS_PER_CYCLE + 1 cycles (5, 3 or 2).
REQ-020 Back-pressure: out_ready low in HOLD stalls indefinitely; in_ready stays 0 throughout.
REQ-021 The latched mode applies to the whole block; changing mode or in_valid after accept has no effect.
REQ-022 GF(2^8) arithmetic uses the reduction polynomial 0x11B; xtime(a) = {a[6:0],0} ^ (a[7] ? 0x1B : 0).
REQ-023 Inverse coefficients are built from chained xtime only (x4 = xtime(xtime(a)), x8 = xtime(x4)); no multipliers and no lookup ROMs.
REQ-024 Forward result = MixColumns from FIPS-197 section 5.1.3; inverse result = InvMixColumns from section 5.3.3; inverse(forward(x)) = x for every x.
REQ-025 With REG_OUT = 0, out_valid in HOLD behaves the same as with REG_OUT = 1; only the data_out timing path differs.

Reset
REQ-026 rst_n low, asynchronously: state = IDLE, beat counter = 0, result register = 0, latched mode = 0.
REQ-027 Output values in reset: out_valid = 0, busy = 0, data_out = 0.
REQ-028 Output values in reset: in_ready = 0 while rst_n is low; in_ready = 1 from the first clock edge after rst_n goes high.
REQ-029 Reset during CALC or HOLD discards the block; no partial result is ever flagged valid.

Structure
REQ-030 Shared package aes_pkg holds AES_POLY = 8'h1B, the MODE_FWD / MODE_INV constants and the state enum type.
REQ-031 Sub-module gf_mix_col: purely combinational, one 32-bit column plus mode in, one 32-bit column out; instantiated COLS_PER_CYCLE times.
REQ-032 Column selection into and out of gf_mix_col is a mux indexed by the beat counter; no other arithmetic in the top level.

Verification
REQ-033 Fwd, column db135345 (all four columns) -> 8e4da1bc in every column; out_valid high 5 cycles after accept with COLS_PER_CYCLE = 1.
REQ-034 Fwd, columns f20a225c, 01010101, c6c6c6c6, d4d4d4d5 -> 9fdc589d, 01010101, c6c6c6c6, d5d5d7d6; then inv on that result returns the input.
REQ-035 Inv, column 8e4da1bc -> db135345; repeat for COLS_PER_CYCLE = 2 and 4 with latencies of 3 and 2 cycles.
REQ-036 Hold out_ready = 0 for 10 cycles in HOLD -> data_out stable, in_ready = 0, second in_valid ignored; accepted after the handshake.
REQ-037 Drop rst_n during beat 2 of CALC -> outputs go to reset values immediately, no out_valid follows; a new block is then processed correctly.
REQ-038 Random 10k blocks, both modes, all parameter sets, compared against a reference model; handshake and stability assertions always on.
